// File: rtl/ex_5_16_exact_mag.sv
// ex_5_16_exact_mag
// Sequential exact magnitude: y = floor(sqrt(A*A + B*B)) for unsigned 16-bit
// operands. The radicand is formed in one cycle, then a restoring
// digit-by-digit square root yields one root bit per clock, MSB first.
// One result every 19 cycles; upstream paces itself on 'ready'.
//
// Ports
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   dv       operand-valid strobe; a pair is taken only when dv=1 and ready=1
//   inpA     unsigned operand A (16 bits)
//   inpB     unsigned operand B (16 bits)
//   ready    registered; 1 = an operand pair can be accepted on this edge
//   y        registered result (17 bits), held until the next result
//   y_valid  registered one-cycle pulse per result
module ex_5_16_exact_mag (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dv,
    input  logic [15:0] inpA,
    input  logic [15:0] inpB,
    output logic        ready,
    output logic [16:0] y,
    output logic        y_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        ROOT   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    // Radicand with a leading zero so it splits into 17 bit pairs; shifted
    // left two bits per iteration so the next pair is always at [33:32].
    logic [33:0] n_reg;
    logic [16:0] root_reg;
    // The remainder never exceeds 2*root (< 2^18); 19 bits leaves headroom.
    logic [18:0] rem_reg;
    logic [4:0]  cnt_reg;
    logic [16:0] y_reg;
    logic        y_valid_reg;
    logic        ready_reg;

    // Radicand: two exact 32-bit squares summed at 33 bits, no truncation.
    logic [31:0] a_sq;
    logic [31:0] b_sq;
    logic [32:0] n_sum;

    assign a_sq  = a_reg * a_reg;
    assign b_sq  = b_reg * b_reg;
    assign n_sum = {1'b0, a_sq} + {1'b0, b_sq};

    // One restoring root step: bring down the next radicand pair, try to
    // subtract (root<<2)|1, and keep the difference only if it fits.
    logic [20:0] rem_shift;
    logic [20:0] trial;
    logic        fits;
    logic [18:0] rem_next;
    logic [16:0] root_next;

    always_comb begin
        rem_shift = {rem_reg, n_reg[33:32]};
        trial     = {2'b00, root_reg, 2'b01};
        fits      = (rem_shift >= trial);
        rem_next  = fits ? 19'(rem_shift - trial) : rem_shift[18:0];
        root_next = {root_reg[15:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            n_reg       <= '0;
            root_reg    <= '0;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
            ready_reg   <= 1'b0;
        end else begin
            y_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // ready_reg is still 0 on the first edge after reset, so
                    // nothing is accepted until ready has been visible.
                    if (dv && ready_reg) begin
                        a_reg     <= inpA;
                        b_reg     <= inpB;
                        ready_reg <= 1'b0;
                        state_reg <= SQUARE;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                SQUARE: begin
                    n_reg     <= {1'b0, n_sum};
                    root_reg  <= '0;
                    rem_reg   <= '0;
                    cnt_reg   <= 5'd16;
                    state_reg <= ROOT;
                end
                ROOT: begin
                    n_reg    <= {n_reg[31:0], 2'b00};
                    root_reg <= root_next;
                    rem_reg  <= rem_next;
                    if (cnt_reg == 5'd0) begin
                        // Last bit: publish the root; the remainder is dropped.
                        y_reg       <= root_next;
                        y_valid_reg <= 1'b1;
                        ready_reg   <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 5'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready   = ready_reg;
    assign y       = y_reg;
    assign y_valid = y_valid_reg;

endmodule

// File: tb/tb_ex_5_16_exact_mag.sv
// Self-checking bench for ex_5_16_exact_mag.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge. k counts falling edges after the accept edge T0 (k=0 is right after
// T0); y_valid is expected at k=18, i.e. the value a rising-edge sampler
// would see at T0+19.
module tb_ex_5_16_exact_mag;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dv;
    logic [15:0] inpA;
    logic [15:0] inpB;
    logic        ready;
    logic [16:0] y;
    logic        y_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_5_16_exact_mag dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dv      (dv),
        .inpA    (inpA),
        .inpB    (inpB),
        .ready   (ready),
        .y       (y),
        .y_valid (y_valid)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] exp_y;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Integer square root by binary search on r*r <= n.
    function automatic logic [16:0] isqrt(input longint unsigned n);
        longint unsigned lo = 0;
        longint unsigned hi = 64'd131072;
        longint unsigned mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid;
        end
        return lo[16:0];
    endfunction

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, " ready_wait"}, 64'(ready), 64'd1);
    endtask

    // Called at falling edge k0 after the accept edge.
    task automatic wait_result(input int k0, input logic [16:0] exp_y, input string nm);
        int k = k0;
        int rl = 0;
        while (!y_valid && k < 60) begin
            if (!ready) rl++;
            @(negedge clk);
            k++;
        end
        check({nm, " y_valid"}, 64'(y_valid), 64'd1);
        if (y_valid) begin
            check({nm, " latency"}, 64'(k), 64'd18);
            check({nm, " y"}, 64'(y), 64'(exp_y));
            check({nm, " ready_at_valid"}, 64'(ready), 64'd1);
            check({nm, " ready_low_cycles"}, 64'(rl), 64'(18 - k0));
        end
        $display("txn %s: y=%0d expected=%0d latency=%0d", nm, y, exp_y, k);
    endtask

    task automatic run_pair(input logic [15:0] a, input logic [15:0] b,
                            input logic [16:0] exp_y, input string nm);
        wait_ready(nm);
        inpA = a;
        inpB = b;
        dv   = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        wait_result(0, exp_y, nm);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [15:0] ra;
        logic [15:0] rb;
        longint unsigned la;
        longint unsigned lb;

        vecs[0] = '{16'd0,     16'd0,     17'd0};
        vecs[1] = '{16'd1000,  16'd999,   17'd1413};
        vecs[2] = '{16'd65535, 16'd0,     17'd65535};
        vecs[3] = '{16'd65535, 16'd65535, 17'd92680};
        vecs[4] = '{16'd0,     16'd65535, 17'd65535};
        vecs[5] = '{16'd1,     16'd1,     17'd1};
        vecs[6] = '{16'd2,     16'd3,     17'd3};
        vecs[7] = '{16'd255,   16'd255,   17'd360};
        vecs[8] = '{16'd20,    16'd21,    17'd29};
        vecs[9] = '{16'd1,     16'd0,     17'd1};

        // Reset
        reset_n = 1'b0;
        dv      = 1'b0;
        inpA    = '0;
        inpB    = '0;
        repeat (3) @(negedge clk);
        check("reset ready", 64'(ready), 64'd0);
        check("reset y", 64'(y), 64'd0);
        check("reset y_valid", 64'(y_valid), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("release ready", 64'(ready), 64'd1);

        // First pair, single-pulse and hold checks
        run_pair(16'd3, 16'd4, 17'd5, "a3_b4");
        @(negedge clk);
        check("a3_b4 pulse_width", 64'(y_valid), 64'd0);
        check("a3_b4 y_hold", 64'(y), 64'd5);

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            run_pair(vecs[i].a, vecs[i].b, vecs[i].exp_y, $sformatf("vec%0d", i));
        end

        // Busy drop, then back-to-back acceptance in the y_valid cycle
        wait_ready("busy");
        inpA = 16'd6;
        inpB = 16'd8;
        dv   = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        repeat (4) @(negedge clk);
        inpA = 16'd5;
        inpB = 16'd12;
        dv   = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        wait_result(5, 17'd10, "busy_first");
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        wait_result(0, 17'd13, "back_to_back");
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (y_valid) pulses++;
        end
        check("busy extra_pulses", 64'(pulses), 64'd0);

        // Reset mid-operation
        wait_ready("midreset");
        inpA = 16'd300;
        inpB = 16'd400;
        dv   = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midreset y", 64'(y), 64'd0);
        check("midreset y_valid", 64'(y_valid), 64'd0);
        check("midreset ready", 64'(ready), 64'd0);
        @(negedge clk);
        check("midreset ready_after", 64'(ready), 64'd1);
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (y_valid) pulses++;
        end
        check("midreset no_result", 64'(pulses), 64'd0);
        run_pair(16'd20, 16'd21, 17'd29, "after_reset");

        // Random soak with random idle gaps
        for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = 16'($urandom);
            rb = 16'($urandom);
            la = 64'(ra);
            lb = 64'(rb);
            run_pair(ra, rb, isqrt(la * la + lb * lb), $sformatf("soak%0d_%0d_%0d", i, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_5_16_exact_mag.md
# ex_5_16_exact_mag

Sequential exact-magnitude unit: computes y = floor(sqrt(A² + B²)) for unsigned 16-bit operand pairs using one digit-by-digit square-root iteration per clock. It shares the dv / y / y_valid stream protocol of the alpha-max-beta-min magnitude approximator and sits beside it as the exact-result producer. Its results feed the approximator's on-chip error checker, and it replaces the software `$sqrt` model in benches. It trades throughput (one result per 19 cycles) for exactness and exposes a ready flag so upstream logic can pace it.

## Interface
- No parameters; widths are fixed.
- clk      input   1   rising-edge clock
- reset_n  input   1   synchronous, active-low reset (sampled on rising edge of clk)
- dv       input   1   operand-valid strobe; a pair is accepted only on an edge where dv=1 and ready=1
- inpA     input   16  unsigned operand A
- inpB     input   16  unsigned operand B
- ready    output  1   registered; 1 = an operand pair can be accepted on this edge
- y        output  17  registered; floor(sqrt(A²+B²)), valid when y_valid=1, held until next result
- y_valid  output  1   registered; one-cycle pulse per result

## Operation
- States: IDLE, SQUARE, ROOT, and no others.
- IDLE (ready=1)
  - Accept edge with dv=1: capture inpA and inpB, then go to SQUARE.
  - With dv=0, stay in IDLE.
- SQUARE (ready=0)
  - Register radicand N = A*A + B*B at 33 bits, zero-extended, with no truncation. Max N = 2·65535² = 8 589 672 450.
  - Clear the partial root and remainder.
  - Load iteration counter = 16, then go to ROOT.
- ROOT (ready=0)
  - Restoring digit-by-digit square root, producing one root bit per edge, MSB (bit 16) first.
  - Each iteration brings down the next 2 radicand bits, MSB pair first. N is treated as 34 bits with a leading 0.
  - Trial subtrahend = (root<<2)|1. If it does not exceed the remainder, subtract it and set the root bit; otherwise leave the remainder and clear the bit.
  - Remainder register is at least 19 bits wide.
  - 17 iterations total: counter 16 down to 0.
  - On the counter=0 iteration: load y with the final root, pulse y_valid=1, set ready=1, go to IDLE.
- dv while ready=0: ignored. The operands are dropped, with no error indication and no queueing.
- Result: exact floor of the true square root. No rounding; the remainder is discarded.
- Reset values (reset_n=0 on an edge): state=IDLE, ready=0, y=0, y_valid=0, all internal registers 0.
  - ready rises to 1 on the first edge with reset_n=1.
- Reset mid-operation (SQUARE or ROOT): abort immediately, with no y_valid for the aborted pair. The reset values above apply.

## Timing
- Edges are numbered from the accept edge T0, where dv=1 and ready=1 are sampled.
- T0: ready falls (visible after T0).
- T0+1: SQUARE completes.
- T0+2 … T0+18: ROOT iterations for bits 16 down to 0.
- After T0+18: y_valid=1, y is valid, ready=1, all for exactly one cycle of y_valid.
- Latency: 18 edges from the accept edge to the y_valid edge.
  - A bench sampling at the next rising edge sees y_valid=1 at edge T0+19.
- Back-to-back: dv=1 during the y_valid cycle is accepted at edge T0+19, so sustained throughput is one pair per 19 cycles.
- y_valid is deasserted on every edge except the completion edge. y holds its value between results.
- ready and y_valid are never both 1 except in the completion cycle.

## Test plan
- Reset release, then A=3, B=4 with dv=1 one cycle → y=5, y_valid single pulse sampled 19 edges after the accept edge; ready low for exactly 18 cycles.
- A=0,B=0 → y=0. A=1000,B=999 (N=1 998 001) → y=1413. A=65535,B=0 → y=65535.
- A=65535, B=65535 (N=8 589 672 450) → y=92680. This checks the 33-bit radicand with no overflow.
- Busy drop: accept A=6,B=8, then pulse dv with A=5,B=12 at T0+5 → only one result, y=10.
  - Then hold dv=1 with A=5,B=12 through the y_valid cycle → second result y=13 exactly 19 edges later.
- Reset mid-op: accept A=300,B=400, drive reset_n=0 at T0+10 for one edge → y=0 and y_valid=0 with no result pulse; ready=1 after release.
  - Next pair A=20,B=21 → y=29.
- Random soak: 500 random pairs with random dv gaps → every y equals floor(sqrt(A²+B²)) from the bench model, in order, one per accepted pair.
